// File: rtl/jtdsp16_pkg.sv
// Shared types and constants for the DSP16 program memory block.
// Holds the PC-port FSM state encoding, the pc_dout source selector,
// the default external wait limit and the fill word returned on timeout.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    DONE     = 2'd2
  } pc_state_t;

  // Which register currently drives pc_dout
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_EXT  = 2'd2
  } pc_src_t;

  localparam int          WAIT_MAX_DEF = 15;
  localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/jtdsp16_dpram.sv
// One byte lane of the program ROM: a simple dual-port array.
// Port A writes (programming) and reads (table pointer); port B reads (PC fetch).
// Both read ports are registered and only update when their enable is high,
// so the output holds the last value read. Reads see the contents from
// before any write made on the same edge.
module jtdsp16_dpram
  import jtdsp16_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic          re_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] q_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Port A: write plus registered read of the same address
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (re_a) q_a <= mem[addr_a];
  end

  // Port B: registered read only
  always_ff @(posedge clk) begin
    if (re_b) q_b <= mem[addr_b];
  end

endmodule

// File: rtl/jtdsp16_pmem.sv
// DSP16 program memory: internal byte-programmable ROM of 2^AW 16-bit words,
// a PC fetch port that falls back to an external memory handshake with a
// timeout, and an independent table-pointer read port on the internal ROM.
// Optional feature: define JTDSP16_PMEM_CHKSUM_EN to build a running sum of
// all programmed bytes on chk_sum; otherwise chk_sum is tied to zero.
module jtdsp16_pmem
  import jtdsp16_pkg::*;
#(
  parameter int AW       = 12,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  // program-counter fetch port
  input  logic [15:0]   pc_addr,
  input  logic          pc_rd,
  output logic [15:0]   pc_dout,
  output logic          pc_ok,
  output logic          pc_busy,
  // table-pointer read port
  input  logic [AW-1:0] pt_addr,
  input  logic          pt_rd,
  output logic [15:0]   pt_dout,
  output logic          pt_ok,
  // external memory
  input  logic          ext_mode,
  output logic [15:0]   ext_addr,
  output logic          ext_cs,
  input  logic [15:0]   ext_data,
  input  logic          ext_ok,
  output logic          ext_err,
  // byte programming
  input  logic [AW:0]   prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          prog_we,
  output logic [15:0]   chk_sum
);

  // Counter value on which the last allowed wait cycle ends; the access
  // times out after exactly WAIT_MAX cycles in EXT_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  pc_state_t state_reg, state_next;
  pc_src_t   pc_src_reg, pc_src_next;
  logic [15:0] ext_addr_reg, ext_addr_next;
  logic [15:0] ext_dout_reg, ext_dout_next;
  logic        ext_cs_reg, ext_cs_next;
  logic        ext_err_reg, ext_err_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        int_ok_reg, int_ok_next;
  logic        pc_re;
  logic        pc_is_int;

  logic        pt_re;
  logic        pt_ok_reg;
  logic        pt_valid_reg;

  logic [AW-1:0]  addr_a;
  logic [1:0][7:0] lane_q_a;
  logic [1:0][7:0] lane_q_b;

  // Internal only when not forced external and the upper address bits are clear
  assign pc_is_int = !ext_mode && ((pc_addr >> AW) == 16'd0);

  // Port A is shared: a programming write takes the port and blocks a PT read
  assign addr_a = prog_we ? prog_addr[AW:1] : pt_addr;
  assign pt_re  = cen && pt_rd && !prog_we;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      jtdsp16_dpram #(
        .AW (AW),
        .DW (8)
      ) u_ram (
        .clk    (clk),
        .we_a   (prog_we && (prog_addr[0] == 1'(gi))),
        .re_a   (pt_re),
        .addr_a (addr_a),
        .din_a  (prog_data),
        .q_a    (lane_q_a[gi]),
        .re_b   (pc_re),
        .addr_b (pc_addr[AW-1:0]),
        .q_b    (lane_q_b[gi])
      );
    end
  endgenerate

  // PC port next-state and register updates
  always_comb begin
    state_next    = state_reg;
    pc_src_next   = pc_src_reg;
    ext_addr_next = ext_addr_reg;
    ext_dout_next = ext_dout_reg;
    ext_cs_next   = ext_cs_reg;
    ext_err_next  = 1'b0;
    wait_cnt_next = wait_cnt_reg;
    int_ok_next   = 1'b0;
    pc_re         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cen && pc_rd) begin
          if (pc_is_int) begin
            pc_re       = 1'b1;
            int_ok_next = 1'b1;
            pc_src_next = SRC_RAM;
          end else begin
            state_next    = EXT_WAIT;
            ext_addr_next = pc_addr;
            ext_cs_next   = 1'b1;
            wait_cnt_next = 8'd0;
          end
        end
      end
      EXT_WAIT: begin
        if (ext_ok) begin
          ext_dout_next = ext_data;
          pc_src_next   = SRC_EXT;
          ext_cs_next   = 1'b0;
          state_next    = DONE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          ext_dout_next = TIMEOUT_FILL;
          pc_src_next   = SRC_EXT;
          ext_err_next  = 1'b1;
          ext_cs_next   = 1'b0;
          state_next    = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // PC port state register and its datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_src_reg   <= SRC_ZERO;
      ext_addr_reg <= 16'd0;
      ext_dout_reg <= 16'd0;
      ext_cs_reg   <= 1'b0;
      ext_err_reg  <= 1'b0;
      wait_cnt_reg <= 8'd0;
      int_ok_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_src_reg   <= pc_src_next;
      ext_addr_reg <= ext_addr_next;
      ext_dout_reg <= ext_dout_next;
      ext_cs_reg   <= ext_cs_next;
      ext_err_reg  <= ext_err_next;
      wait_cnt_reg <= wait_cnt_next;
      int_ok_reg   <= int_ok_next;
    end
  end

  // pc_dout selects the RAM read register or the external capture register
  always_comb begin
    pc_dout = 16'd0;
    case (pc_src_reg)
      SRC_RAM:  pc_dout = lane_q_b;
      SRC_EXT:  pc_dout = ext_dout_reg;
      default:  pc_dout = 16'd0;
    endcase
  end

  assign pc_ok    = int_ok_reg || (state_reg == DONE);
  assign pc_busy  = (state_reg != IDLE);
  assign ext_addr = ext_addr_reg;
  assign ext_cs   = ext_cs_reg;
  assign ext_err  = ext_err_reg;

  // PT port: one-cycle ok pulse; output masked to zero until the first read after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_ok_reg    <= 1'b0;
      pt_valid_reg <= 1'b0;
    end else begin
      pt_ok_reg <= pt_re;
      if (pt_re) pt_valid_reg <= 1'b1;
    end
  end

  assign pt_ok   = pt_ok_reg;
  assign pt_dout = pt_valid_reg ? lane_q_a : 16'd0;

`ifdef JTDSP16_PMEM_CHKSUM_EN
  logic [15:0] chk_sum_reg;

  // Running modulo-2^16 sum of every programmed byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_sum_reg <= 16'd0;
    end else if (prog_we) begin
      chk_sum_reg <= chk_sum_reg + {8'd0, prog_data};
    end
  end

  assign chk_sum = chk_sum_reg;
`else
  assign chk_sum = 16'd0;
`endif

endmodule
